// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared widths and state type for the ADC scan sequencer
//
// Purpose: channel count, address/data widths and the sequencer state enum.
// Ports: none (package).
package adc_pkg;

  localparam int NCH    = 8;
  localparam int CH_W   = 3;
  localparam int DATA_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/adc_next_chan.sv
// rtl/adc_next_chan.sv - next enabled channel search, ascending with wrap
//
// Purpose: given the enable mask and the current channel, return the first
//          enabled channel strictly above cur_i (wrapping), or cur_i itself
//          when it is the only enabled channel. Pure combinational.
// Ports:
//   mask_i  [NCH-1:0]  channel enable mask
//   cur_i   [CH_W-1:0] current channel
//   next_o  [CH_W-1:0] next enabled channel (cur_i when none found)
//   found_o            any channel enabled
module adc_next_chan
  import adc_pkg::*;
(
  input  logic [NCH-1:0]  mask_i,
  input  logic [CH_W-1:0] cur_i,
  output logic [CH_W-1:0] next_o,
  output logic            found_o
);

  logic [CH_W-1:0] idx;

  // Walk from the farthest offset down to the nearest so the nearest
  // enabled channel is the last one written. Offset NCH lands on cur_i.
  always_comb begin
    next_o  = cur_i;
    found_o = 1'b0;
    idx     = '0;
    for (int i = NCH; i >= 1; i--) begin
      idx = cur_i + CH_W'(i);
      if (mask_i[idx]) begin
        next_o  = idx;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - round-robin scan sequencer for a pipelined SPI ADC
//
// Purpose: walks the enabled channels, drives the SPI front end address, tags
//          each one-frame-late result with its channel, streams it out and
//          keeps a latest-sample table.
// Ports:
//   clk, reset_b                 clock, async active-low reset
//   start, stop                  one-cycle control pulses
//   chan_en      [NCH-1:0]       channel enable mask
//   spi_valid, spi_data          frame-complete strobe and result
//   spi_add, spi_reset_b         address and hold to the SPI front end
//   sample_valid/ready/chan/data output sample stream
//   rd_chan, rd_data             combinational table read
//   busy, overrun                not idle; sticky overwrite flag
module adc_scan_sequencer
  import adc_pkg::*;
(
  input  logic              clk,
  input  logic              reset_b,
  input  logic              start,
  input  logic              stop,
  input  logic [NCH-1:0]    chan_en,
  input  logic              spi_valid,
  input  logic [DATA_W-1:0] spi_data,
  output logic [CH_W-1:0]   spi_add,
  output logic              spi_reset_b,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic [CH_W-1:0]   sample_chan,
  output logic [DATA_W-1:0] sample_data,
  input  logic [CH_W-1:0]   rd_chan,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              overrun
);

  state_e            state_q;
  logic [CH_W-1:0]   cur_chan_q;
  logic [CH_W-1:0]   pend_chan_q;
  logic              stop_pend_q;
  logic              sample_valid_q;
  logic [CH_W-1:0]   sample_chan_q;
  logic [DATA_W-1:0] sample_data_q;
  logic              overrun_q;
  logic [DATA_W-1:0] table_q [NCH];

  logic [CH_W-1:0]   adv_chan;
  logic              adv_found;
  logic [CH_W-1:0]   first_chan;
  logic              first_found;
  logic              emit;

  adc_next_chan u_adv (
    .mask_i  (chan_en),
    .cur_i   (cur_chan_q),
    .next_o  (adv_chan),
    .found_o (adv_found)
  );

  // Searching "above the top channel" wraps to the lowest enabled channel.
  adc_next_chan u_first (
    .mask_i  (chan_en),
    .cur_i   (CH_W'(NCH - 1)),
    .next_o  (first_chan),
    .found_o (first_found)
  );

  // Frames completing in SCAN or DRAIN carry the pending channel's result;
  // the PRIME frame only fills the ADC pipeline.
  assign emit = spi_valid && (state_q == ST_SCAN || state_q == ST_DRAIN);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q        <= ST_IDLE;
      cur_chan_q     <= '0;
      pend_chan_q    <= '0;
      stop_pend_q    <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_chan_q  <= '0;
      sample_data_q  <= '0;
      overrun_q      <= 1'b0;
      for (int i = 0; i < NCH; i++) table_q[i] <= '0;
    end else begin
      if (emit) begin
        sample_valid_q       <= 1'b1;
        sample_chan_q        <= pend_chan_q;
        sample_data_q        <= spi_data;
        table_q[pend_chan_q] <= spi_data;
        if (sample_valid_q && !sample_ready) overrun_q <= 1'b1;
      end else if (sample_ready) begin
        sample_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          stop_pend_q <= 1'b0;
          if (start && !stop && first_found) begin
            cur_chan_q <= first_chan;
            overrun_q  <= 1'b0;
            state_q    <= ST_PRIME;
          end
        end
        ST_PRIME: begin
          if (stop) stop_pend_q <= 1'b1;
          if (spi_valid) begin
            if (stop || stop_pend_q) begin
              state_q <= ST_IDLE;
            end else begin
              pend_chan_q <= cur_chan_q;
              if (adv_found) begin
                cur_chan_q <= adv_chan;
                state_q    <= ST_SCAN;
              end else begin
                state_q <= ST_DRAIN;
              end
            end
          end
        end
        ST_SCAN: begin
          if (spi_valid) begin
            pend_chan_q <= cur_chan_q;
            if (adv_found) cur_chan_q <= adv_chan;
            if (stop || !adv_found) state_q <= ST_DRAIN;
          end else if (stop) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (spi_valid) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign spi_add      = cur_chan_q;
  assign spi_reset_b  = (state_q != ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign sample_valid = sample_valid_q;
  assign sample_chan  = sample_chan_q;
  assign sample_data  = sample_data_q;
  assign overrun      = overrun_q;
  assign rd_data      = table_q[rd_chan];

endmodule
